// File: rtl/fm_freq_word_bank.sv
// Double-buffered multi-channel tuning-word bank: host writes fill shadows, a committed
// transfer copies all shadows to the active words on the next phase-sync strobe.
// Optional shadow readback port is built when FM_FREQ_READBACK_EN is defined.
module fm_freq_word_bank #(
  parameter int WIDTH    = 48,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
`ifdef FM_FREQ_READBACK_EN
  input  logic [CH_BITS-1:0]        rd_ch_i,
  output logic [WIDTH-1:0]          rd_data_o,
`endif
  input  logic                      wr_en_i,
  input  logic [CH_BITS-1:0]        wr_ch_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic                      commit_req_i,
  input  logic                      commit_sync_i,
  output logic [CHANNELS*WIDTH-1:0] dout_o,
  output logic                      pending_o,
  output logic                      commit_ack_o,
  output logic                      err_overrun_o
);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t           state_q, state_d;
  logic             commit_fire;
  logic             overrun_set;
  logic             ack_q;
  logic             err_q;
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];

  // shadow_d is the post-write shadow; committing from it gives the same-cycle write bypass.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic wr_sel;
    assign wr_sel                        = wr_en_i && (wr_ch_i == CH_BITS'(gi));
    assign shadow_d[gi]                  = wr_sel ? wr_data_i : shadow_q[gi];
    assign dout_o[gi*WIDTH +: WIDTH]     = active_q[gi];
  end

  always_comb begin
    state_d     = state_q;
    commit_fire = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req_i) state_d = ARMED;
      end
      ARMED: begin
        if (commit_sync_i) begin
          commit_fire = 1'b1;
          state_d     = IDLE;
        end else if (commit_req_i) begin
          overrun_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= commit_fire;
      err_q   <= err_q | overrun_set;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (commit_fire) active_q[i] <= shadow_d[i];
      end
    end
  end

  assign pending_o     = (state_q == ARMED);
  assign commit_ack_o  = ack_q;
  assign err_overrun_o = err_q;

`ifdef FM_FREQ_READBACK_EN
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Unmapped channel addresses read back as zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_ch_i == CH_BITS'(i)) rd_data_d = shadow_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;
`endif

endmodule

// File: tb/tb_fm_freq_word_bank.sv
// Randomized + directed bench for fm_freq_word_bank: a 4-channel and a 3-channel instance
// share stimulus and are compared every cycle against a behavioural bank model.
module tb_fm_freq_word_bank;
  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_ch = '0;
  logic [W-1:0] wr_data = '0;
  logic         req = 1'b0;
  logic         sync = 1'b0;
  logic [1:0]   rd_ch = '0;

  logic [4*W-1:0] dout4;
  logic [3*W-1:0] dout3;
  logic           pend4, pend3, ack4, ack3, ovr4, ovr3;
  logic [W-1:0]   rd4, rd3;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;
  int  pcnt;

  always #5 clk = ~clk;

  fm_freq_word_bank #(.WIDTH(W), .CHANNELS(4), .CH_BITS(2)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef FM_FREQ_READBACK_EN
    .rd_ch_i(rd_ch), .rd_data_o(rd4),
`endif
    .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_data_i(wr_data),
    .commit_req_i(req), .commit_sync_i(sync),
    .dout_o(dout4), .pending_o(pend4), .commit_ack_o(ack4), .err_overrun_o(ovr4)
  );

  fm_freq_word_bank #(.WIDTH(W), .CHANNELS(3), .CH_BITS(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
`ifdef FM_FREQ_READBACK_EN
    .rd_ch_i(rd_ch), .rd_data_o(rd3),
`endif
    .wr_en_i(wr_en), .wr_ch_i(wr_ch), .wr_data_i(wr_data),
    .commit_req_i(req), .commit_sync_i(sync),
    .dout_o(dout3), .pending_o(pend3), .commit_ack_o(ack3), .err_overrun_o(ovr3)
  );

`ifndef FM_FREQ_READBACK_EN
  assign rd4 = '0;
  assign rd3 = '0;
`endif

  // ---------------- behavioural model: index 0 = 4-channel, 1 = 3-channel ----------------
  logic [W-1:0] m_shadow [2][4];
  logic [W-1:0] m_active [2][4];
  logic [W-1:0] m_rd [2];
  logic         m_armed [2];
  logic         m_ack [2];
  logic         m_ovr [2];

  function automatic int nch(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // Shadow content of channel c as it stands after the current edge's write.
  function automatic logic [W-1:0] peek(int i, int c);
    return (wr_en && int'(wr_ch) == c) ? wr_data : m_shadow[i][c];
  endfunction

  function automatic logic [4*W-1:0] pack(int i);
    logic [4*W-1:0] v;
    v = '0;
    for (int c = 0; c < nch(i); c++) v[c*W +: W] = m_active[i][c];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_armed[i] <= 1'b0;
        m_ack[i]   <= 1'b0;
        m_ovr[i]   <= 1'b0;
        m_rd[i]    <= '0;
        for (int c = 0; c < 4; c++) begin
          m_shadow[i][c] <= '0;
          m_active[i][c] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ack[i] <= m_armed[i] && sync;
        if (m_armed[i] && sync) m_armed[i] <= 1'b0;
        else if (req)           m_armed[i] <= 1'b1;
        if (m_armed[i] && req && !sync) m_ovr[i] <= 1'b1;
        m_rd[i] <= (int'(rd_ch) < nch(i)) ? peek(i, int'(rd_ch)) : '0;
        for (int c = 0; c < nch(i); c++) begin
          if (wr_en && int'(wr_ch) == c) m_shadow[i][c] <= wr_data;
          if (m_armed[i] && sync)        m_active[i][c] <= peek(i, c);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout4", dout4, pack(0));
      chk("dout3", {{W{1'b0}}, dout3}, pack(1));
      chk("pending4", {191'b0, pend4}, {191'b0, m_armed[0]});
      chk("pending3", {191'b0, pend3}, {191'b0, m_armed[1]});
      chk("ack4", {191'b0, ack4}, {191'b0, m_ack[0]});
      chk("ack3", {191'b0, ack3}, {191'b0, m_ack[1]});
      chk("ovr4", {191'b0, ovr4}, {191'b0, m_ovr[0]});
      chk("ovr3", {191'b0, ovr3}, {191'b0, m_ovr[1]});
`ifdef FM_FREQ_READBACK_EN
      chk("rd4", {144'b0, rd4}, {144'b0, m_rd[0]});
      chk("rd3", {144'b0, rd3}, {144'b0, m_rd[1]});
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    req   = 1'b0;
    sync  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_dout", dout4, '0);
    chk("reset_pending", {191'b0, pend4}, '0);

    // Writes alone never reach Dout; then a commit with the sync 5 cycles after the request.
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 48'h0000_1000_0000; cyc();
    wr_ch = 2'd3; wr_data = 48'h0000_2000_0000; cyc();
    idle(); cyc(); cyc();
    chk("s2_no_commit_hold", dout4, '0);
    req = 1'b1; cyc(); req = 1'b0;
    pcnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (pend4) pcnt++;
      if (k == 4) sync = 1'b1;
      cyc();
    end
    sync = 1'b0;
    chk("s2_pending_cycles", 192'(pcnt), 192'd5);
    chk("s2_dout4", dout4, {48'h0000_2000_0000, 96'b0, 48'h0000_1000_0000});
    chk("s2_dout3_ch3_ignored", {{W{1'b0}}, dout3}, {144'b0, 48'h0000_1000_0000});
    chk("s2_ack", {191'b0, ack4}, 192'd1);
    chk("s2_pending_clear", {191'b0, pend4}, '0);
    cyc();
    chk("s2_ack_one_cycle", {191'b0, ack4}, '0);

    // Request and sync together from IDLE: no transfer until the following sync.
    wr_en = 1'b1; wr_ch = 2'd2; wr_data = 48'h0000_0000_5555; cyc();
    idle(); req = 1'b1; sync = 1'b1; cyc(); idle();
    chk("s3_no_xfer", dout4[2*W +: W], '0);
    chk("s3_armed", {191'b0, pend4}, 192'd1);
    sync = 1'b1; cyc(); sync = 1'b0;
    chk("s3_xfer_next_sync", {144'b0, dout4[2*W +: W]}, {144'b0, 48'h0000_0000_5555});

    // Write bypass on the commit edge, and an out-of-range channel on the 3-channel bank.
    req = 1'b1; cyc(); req = 1'b0;
    wr_en = 1'b1; wr_ch = 2'd1; wr_data = 48'h0000_0000_ABCD; sync = 1'b1; cyc(); idle();
    chk("s4_bypass4", {144'b0, dout4[W +: W]}, {144'b0, 48'h0000_0000_ABCD});
    chk("s4_bypass3", {144'b0, dout3[W +: W]}, {144'b0, 48'h0000_0000_ABCD});
    wr_en = 1'b1; wr_ch = 2'd3; wr_data = 48'h0000_0000_DEAD; req = 1'b1; cyc(); idle();
    sync = 1'b1; cyc(); sync = 1'b0;
    chk("s4_dout3_unchanged", {{W{1'b0}}, dout3},
        {48'b0, 48'h0000_0000_5555, 48'h0000_0000_ABCD, 48'h0000_1000_0000});
    chk("s4_dout4_ch3", {144'b0, dout4[3*W +: W]}, {144'b0, 48'h0000_0000_DEAD});

    // Overrun is sticky across commits; reset while armed drops the pending commit.
    req = 1'b1; cyc(); cyc(); req = 1'b0;
    chk("s5_overrun", {191'b0, ovr4}, 192'd1);
    sync = 1'b1; cyc(); sync = 1'b0;
    chk("s5_overrun_sticky", {191'b0, ovr4}, 192'd1);
    chk("s5_pending_after_commit", {191'b0, pend4}, '0);
    req = 1'b1; cyc(); req = 1'b0;
    chk("s5_armed", {191'b0, pend4}, 192'd1);
    rst_n = 1'b0;
    #1;
    chk("s5_async_pending", {191'b0, pend4}, '0);
    chk("s5_async_dout", dout4, '0);
    chk("s5_async_overrun", {191'b0, ovr4}, '0);
    #1 rst_n = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd0; wr_data = 48'h0000_0000_0077; cyc(); wr_en = 1'b0;
    sync = 1'b1; cyc(); sync = 1'b0;
    chk("s5_no_xfer_after_reset", dout4, '0);
    chk("s5_no_ack_after_reset", {191'b0, ack4}, '0);

`ifdef FM_FREQ_READBACK_EN
    wr_en = 1'b1; wr_ch = 2'd2; wr_data = 48'h0000_0000_1234; rd_ch = 2'd2; cyc();
    wr_en = 1'b0; cyc();
    chk("s6_readback", {144'b0, rd4}, {144'b0, 48'h0000_0000_1234});
    chk("s6_dout_ch2_still_0", {144'b0, dout4[2*W +: W]}, '0);
    rd_ch = 2'd3; cyc();
    chk("s6_rd3_unmapped", {144'b0, rd3}, '0);
`endif

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_data = 48'({$urandom, $urandom});
      req     = ($urandom_range(0, 5) == 0);
      sync    = ($urandom_range(0, 4) == 0);
      rd_ch   = 2'($urandom_range(0, 3));
      cyc();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    idle();
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
